ex_squash_queue: RTL and testbench
==================================

Name: ex_squash_queue

Overview:
- Parametrised execute-to-writeback buffer that sits between an execute unit and the writeback/commit unit.
- Supersedes the fixed single-entry execute queue; a top level can instantiate one per pipe.
- Adds four things: configurable depth, an optional zero-latency bypass, squash filtering by sequence-number age (wrap-aware), and output masking so squashed results never reach writeback.

Parameters:
- p_depth, 2, number of entries (>=1)
- p_seq_num_bits, 5, sequence-number width
- p_phys_addr_bits, 6, physical register address width
- p_bypass, 0, 1 = when the queue is empty, an input may pass straight to the output in the same cycle

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- in_val  in  1  execute result valid
- in_rdy  out  1  queue can accept
- in_seq_num  in  p_seq_num_bits  instruction sequence number
- in_pc  in  32  instruction PC
- in_waddr  in  5  architectural destination register
- in_preg  in  p_phys_addr_bits  physical destination register
- in_wdata  in  32  result data
- in_wen  in  1  result writes a register
- out_val  out  1  result valid to writeback
- out_rdy  in  1  writeback accepts
- out_seq_num, out_pc, out_waddr, out_preg, out_wdata, out_wen  out  widths as the in_* fields  head result
- squash_val  in  1  squash broadcast valid
- squash_seq_num  in  p_seq_num_bits  squashing instruction; strictly younger entries die
- commit_val  in  1  commit broadcast valid
- commit_seq_num  in  p_seq_num_bits  committed instruction

Behaviour:
- Storage:
  - Circular buffer with head pointer, tail pointer and count register (0..p_depth).
  - Pointers wrap at p_depth, including non-power-of-2 depths.
- Age reference:
  - Register `oldest`, reset 0. On commit_val, `oldest` becomes commit_seq_num+1 (mod 2^p_seq_num_bits).
  - Age of x is (x - oldest) mod 2^p_seq_num_bits.
  - x is younger than s iff age(x) > age(s).
  - All comparisons in a cycle use the pre-update `oldest`.
- in_rdy = (count < p_depth). It is registered-state-only: no combinational path from out_rdy. When full, a dequeue in the same cycle does not raise in_rdy that cycle.
- Enqueue: on in_val && in_rdy, write all fields at tail; latency 1 cycle to out_val.
- Dequeue: on out_val && out_rdy, advance head.
- Simultaneous enqueue and dequeue: count unchanged.
- out_val = (count > 0) && !(squash_val && head younger than squash_seq_num).
  - The mask is combinational, so a squashed head is never accepted by writeback.
- Bypass (p_bypass=1 only):
  - Applies when count==0 and in_val.
  - out_* = in_*; out_val = in_val unless the input is younger than an active squash.
  - If out_rdy, the entry is consumed and not enqueued; otherwise it is enqueued normally.
  - With p_bypass=0, out_* depend only on registered state.
- Squash:
  - Entries arrive in program order, so younger entries form a contiguous tail suffix.
  - On squash_val, tail and count retract to the first younger entry. This may empty the queue.
  - An input that is younger than a same-cycle squash is dropped (not enqueued). in_rdy is unaffected.
  - If the head is being dequeued the same cycle, the dequeue is only possible when the head survives; both updates apply.
- Commit and squash in the same cycle: both take effect; squash uses the old `oldest`.
- Output fields when count==0 and no bypass: hold last values. They are don't-care; the bench checks them only when out_val=1.
- Reset (rst=0, any time, including mid-operation):
  - count=0, head=tail=0, oldest=0.
  - out_val=0, in_rdy=1.
  - Storage contents are not cleared.
  - Outputs take the reset values immediately (asynchronous).
- No X propagation on out_val/in_rdy after reset.

Test Plan:
1. Fill/drain, p_depth=2, out_rdy=0:
   - Enqueue seq 1, 2 -> in_rdy=0 after 2nd enqueue; third input (seq 3) is held.
   - Raise out_rdy -> seq 1 then seq 2 appear in order with wdata intact; in_rdy returns the cycle after count<2.
2. Squash tail, p_depth=4:
   - Entries seq 3,4,5,6, oldest=3; squash_seq_num=4 -> count becomes 2.
   - Outputs seq 3 then 4; seq 5/6 never reach out_val.
3. Squash head, same cycle:
   - Head seq 7 with squash_seq_num=6 -> out_val=0 that cycle, even with out_rdy=1.
   - Queue is empty next cycle.
4. Wrap-around age:
   - Commit seq 29 -> oldest=30. Entries seq 30,31,0,1; squash_seq_num=31 -> seq 0 and 1 are dropped (younger despite the smaller value); seq 30 and 31 remain.
5. Bypass, p_bypass=1, empty:
   - in_val with seq 2, out_rdy=1 -> out_val=1 with seq 2 the same cycle; count stays 0.
   - Same stimulus with squash_seq_num=1 -> out_val=0, nothing enqueued.
6. Async reset:
   - With 2 entries queued, pull rst low mid-cycle -> out_val=0 and in_rdy=1 immediately.
   - After release, enqueue seq 0 -> it is dequeued first; no stale entries appear.

Source files
------------

// File: rtl/ex_squash_queue.sv
// ex_squash_queue
//   Execute-to-writeback result buffer with squash filtering.
//   A circular buffer of p_depth entries holds completed execute results until
//   writeback accepts them. Squash broadcasts kill every entry strictly younger
//   than the squashing instruction. Age is measured relative to the oldest
//   uncommitted sequence number, so it stays correct when sequence numbers wrap.
//   A squashed head is masked from out_val combinationally.
//   With p_bypass=1, an input arriving at an empty queue is presented to
//   writeback in the same cycle.
// Ports
//   clk, rst             clock, asynchronous active-low reset
//   in_*                 execute result (valid/ready handshake)
//   out_*                head result to writeback (valid/ready handshake)
//   squash_val/seq_num   squash broadcast; strictly younger entries are dropped
//   commit_val/seq_num   commit broadcast; advances the age reference
module ex_squash_queue #(
  parameter int p_depth          = 2,
  parameter int p_seq_num_bits   = 5,
  parameter int p_phys_addr_bits = 6,
  parameter int p_bypass         = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [p_seq_num_bits-1:0]   in_seq_num,
  input  logic [31:0]                 in_pc,
  input  logic [4:0]                  in_waddr,
  input  logic [p_phys_addr_bits-1:0] in_preg,
  input  logic [31:0]                 in_wdata,
  input  logic                        in_wen,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [p_seq_num_bits-1:0]   out_seq_num,
  output logic [31:0]                 out_pc,
  output logic [4:0]                  out_waddr,
  output logic [p_phys_addr_bits-1:0] out_preg,
  output logic [31:0]                 out_wdata,
  output logic                        out_wen,
  input  logic                        squash_val,
  input  logic [p_seq_num_bits-1:0]   squash_seq_num,
  input  logic                        commit_val,
  input  logic [p_seq_num_bits-1:0]   commit_seq_num
);
  localparam int PW  = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW  = $clog2(p_depth + 1);
  localparam bit BYP = (p_bypass != 0);

  typedef logic [p_seq_num_bits-1:0] seq_t;
  typedef struct packed {
    seq_t                        seq;
    logic [31:0]                 pc;
    logic [4:0]                  waddr;
    logic [p_phys_addr_bits-1:0] preg;
    logic [31:0]                 wdata;
    logic                        wen;
  } ent_t;

  ent_t          r_mem [p_depth];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  seq_t          r_oldest;

  ent_t          w_in_ent, w_head_ent, w_out_ent;
  logic          w_empty, w_in_rdy, w_in_young, w_head_young;
  logic          w_byp, w_byp_take, w_deq, w_enq, w_out_val;
  logic [CW-1:0] w_keep;
  logic [PW-1:0] w_tail_base;

  // x is younger than s when it is further from the oldest live instruction.
  function automatic logic f_younger(seq_t x, seq_t s, seq_t o);
    return seq_t'(x - o) > seq_t'(s - o);
  endfunction

  // Pointer advance by n (n <= p_depth); works for non-power-of-2 depths.
  function automatic logic [PW-1:0] f_wrap(logic [PW-1:0] p, int unsigned n);
    int unsigned t;
    t = 32'(p) + n;
    if (t >= unsigned'(p_depth)) t = t - unsigned'(p_depth);
    return PW'(t);
  endfunction

  assign w_in_ent     = {in_seq_num, in_pc, in_waddr, in_preg, in_wdata, in_wen};
  assign w_head_ent   = r_mem[r_head];
  assign w_empty      = (r_count == '0);
  assign w_in_rdy     = (r_count < CW'(p_depth));
  assign w_in_young   = squash_val && f_younger(in_seq_num, squash_seq_num, r_oldest);
  assign w_head_young = squash_val && f_younger(w_head_ent.seq, squash_seq_num, r_oldest);

  assign w_byp     = BYP && w_empty && in_val;
  assign w_out_val = w_empty ? (w_byp && !w_in_young) : !w_head_young;
  assign w_out_ent = w_byp ? w_in_ent : w_head_ent;

  assign w_deq      = !w_empty && w_out_val && out_rdy;
  // A bypassed input that writeback takes this cycle never occupies a slot.
  assign w_byp_take = w_byp && w_out_val && out_rdy;
  assign w_enq      = in_val && w_in_rdy && !w_in_young && !w_byp_take;

  // Entries are in program order, so survivors of a squash are the run of
  // non-younger entries starting at head; the tail retracts to the first victim.
  always_comb begin
    logic          stop;
    logic [PW-1:0] idx;
    w_keep = r_count;
    stop   = 1'b0;
    idx    = r_head;
    if (squash_val) begin
      w_keep = '0;
      for (int i = 0; i < p_depth; i++) begin
        idx = f_wrap(r_head, unsigned'(i));
        if (!stop && (CW'(i) < r_count) &&
            !f_younger(r_mem[idx].seq, squash_seq_num, r_oldest))
          w_keep = w_keep + CW'(1);
        else
          stop = 1'b1;
      end
    end
  end

  assign w_tail_base = squash_val ? f_wrap(r_head, 32'(w_keep)) : r_tail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_oldest <= '0;
    end else begin
      r_head  <= f_wrap(r_head, 32'(w_deq));
      r_tail  <= f_wrap(w_tail_base, 32'(w_enq));
      r_count <= w_keep - CW'(w_deq) + CW'(w_enq);
      if (commit_val) r_oldest <= commit_seq_num + seq_t'(1);
    end
  end

  // Payload storage is not reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[w_tail_base] <= w_in_ent;
  end

  assign in_rdy  = w_in_rdy;
  assign out_val = w_out_val;
  assign {out_seq_num, out_pc, out_waddr, out_preg, out_wdata, out_wen} = w_out_ent;

endmodule

// File: tb/tb_ex_squash_queue.sv
// Bench for ex_squash_queue. Three instances share one stimulus stream:
//   u0: depth 2, no bypass; u1: depth 4, no bypass; u2: depth 3, bypass.
// A list-based reference model tracks each instance's contents and is
// compared at every falling edge; directed literal checks pin key cycles.
module tb_ex_squash_queue;
  localparam int N = 3;
  localparam int D [N]  = '{2, 4, 3};
  localparam int BY [N] = '{0, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_val = 0, out_rdy = 0, squash_val = 0, commit_val = 0, in_wen = 0;
  logic [4:0]  in_seq = 0, squash_seq = 0, commit_seq = 0, in_waddr = 0;
  logic [31:0] in_pc = 0, in_wdata = 0;
  logic [5:0]  in_preg = 0;

  logic        o_val [N], o_rdy [N], o_wen [N];
  logic [4:0]  o_seq [N], o_waddr [N];
  logic [31:0] o_pc [N], o_wdata [N];
  logic [5:0]  o_preg [N];

  ex_squash_queue #(.p_depth(2), .p_bypass(0)) u0 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(o_rdy[0]), .in_seq_num(in_seq),
    .in_pc(in_pc), .in_waddr(in_waddr), .in_preg(in_preg), .in_wdata(in_wdata), .in_wen(in_wen),
    .out_val(o_val[0]), .out_rdy(out_rdy), .out_seq_num(o_seq[0]), .out_pc(o_pc[0]),
    .out_waddr(o_waddr[0]), .out_preg(o_preg[0]), .out_wdata(o_wdata[0]), .out_wen(o_wen[0]),
    .squash_val(squash_val), .squash_seq_num(squash_seq),
    .commit_val(commit_val), .commit_seq_num(commit_seq));
  ex_squash_queue #(.p_depth(4), .p_bypass(0)) u1 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(o_rdy[1]), .in_seq_num(in_seq),
    .in_pc(in_pc), .in_waddr(in_waddr), .in_preg(in_preg), .in_wdata(in_wdata), .in_wen(in_wen),
    .out_val(o_val[1]), .out_rdy(out_rdy), .out_seq_num(o_seq[1]), .out_pc(o_pc[1]),
    .out_waddr(o_waddr[1]), .out_preg(o_preg[1]), .out_wdata(o_wdata[1]), .out_wen(o_wen[1]),
    .squash_val(squash_val), .squash_seq_num(squash_seq),
    .commit_val(commit_val), .commit_seq_num(commit_seq));
  ex_squash_queue #(.p_depth(3), .p_bypass(1)) u2 (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(o_rdy[2]), .in_seq_num(in_seq),
    .in_pc(in_pc), .in_waddr(in_waddr), .in_preg(in_preg), .in_wdata(in_wdata), .in_wen(in_wen),
    .out_val(o_val[2]), .out_rdy(out_rdy), .out_seq_num(o_seq[2]), .out_pc(o_pc[2]),
    .out_waddr(o_waddr[2]), .out_preg(o_preg[2]), .out_wdata(o_wdata[2]), .out_wen(o_wen[2]),
    .squash_val(squash_val), .squash_seq_num(squash_seq),
    .commit_val(commit_val), .commit_seq_num(commit_seq));

  typedef struct packed {
    logic [4:0]  seq;
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [5:0]  preg;
    logic [31:0] wdata;
    logic        wen;
  } ent_t;

  // Reference model: per instance an ordered list, index 0 = oldest entry.
  ent_t       mbuf [N][8];
  int         mcnt [N];
  logic [4:0] moldest;
  logic       ev_s [N], er_s [N], by_s [N];
  int         npass = 0, ntot = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic young(input logic [4:0] x, input logic [4:0] s);
    return 5'(x - moldest) > 5'(s - moldest);
  endfunction

  function automatic ent_t in_ent();
    return {in_seq, in_pc, in_waddr, in_preg, in_wdata, in_wen};
  endfunction

  initial begin
    moldest = '0;
    for (int k = 0; k < N; k++) begin
      mcnt[k] = 0; ev_s[k] = 0; er_s[k] = 1; by_s[k] = 0;
    end
  end

  always @(negedge rst) begin
    moldest = '0;
    for (int k = 0; k < N; k++) mcnt[k] = 0;
  end

  // Compare process: what each instance must present this cycle.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        logic ev, er, byp;
        ent_t ef, act;
        ev  = 1'b0;
        ef  = '0;
        er  = (mcnt[k] < D[k]);
        byp = (BY[k] != 0) && (mcnt[k] == 0) && in_val;
        if (mcnt[k] > 0) begin
          ev = !(squash_val && young(mbuf[k][0].seq, squash_seq));
          ef = mbuf[k][0];
        end else if (byp) begin
          ev = !(squash_val && young(in_seq, squash_seq));
          ef = in_ent();
        end
        chk($sformatf("u%0d out_val t=%0t", k, $time), 96'(o_val[k]), 96'(ev));
        chk($sformatf("u%0d in_rdy t=%0t", k, $time), 96'(o_rdy[k]), 96'(er));
        if (ev) begin
          act = {o_seq[k], o_pc[k], o_waddr[k], o_preg[k], o_wdata[k], o_wen[k]};
          chk($sformatf("u%0d out_fields t=%0t", k, $time), 96'(act), 96'(ef));
        end
        ev_s[k] = ev; er_s[k] = er; by_s[k] = byp;
      end
    end
  end

  // Model update at the active edge, using the stimulus held through the cycle.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        logic take;
        int   c;
        take = by_s[k] && ev_s[k] && out_rdy;
        if (ev_s[k] && out_rdy && mcnt[k] > 0) begin
          for (int j = 0; j < 7; j++) mbuf[k][j] = mbuf[k][j+1];
          mcnt[k]--;
        end
        if (squash_val) begin
          c = 0;
          for (int j = 0; j < mcnt[k]; j++)
            if (!young(mbuf[k][j].seq, squash_seq)) begin
              mbuf[k][c] = mbuf[k][j];
              c++;
            end
          mcnt[k] = c;
        end
        if (in_val && er_s[k] && !(squash_val && young(in_seq, squash_seq)) && !take) begin
          mbuf[k][mcnt[k]] = in_ent();
          mcnt[k]++;
        end
      end
      if (commit_val) moldest = commit_seq + 5'd1;
    end
  end

  task automatic drive(input logic v, input logic [4:0] s);
    in_val   = v;
    in_seq   = s;
    in_pc    = 32'h1000 + 32'(s) * 4;
    in_waddr = s;
    in_preg  = 6'(s) + 6'd7;
    in_wdata = 32'hA500_0000 | 32'(s);
    in_wen   = s[0];
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    drive(0, 0);
    out_rdy = 0; squash_val = 0; squash_seq = 0; commit_val = 0; commit_seq = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset u%0d out_val", k), 96'(o_val[k]), 96'd0);
      chk($sformatf("reset u%0d in_rdy", k), 96'(o_rdy[k]), 96'd1);
    end
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    // 1. fill / drain
    do_reset();
    drive(1, 1); step();
    chk("t1 u0 first out_val", 96'(o_val[0]), 96'd1);
    chk("t1 u0 first out_seq", 96'(o_seq[0]), 96'd1);
    drive(1, 2); step();
    chk("t1 u0 full in_rdy", 96'(o_rdy[0]), 96'd0);
    drive(1, 3); step();
    chk("t1 u0 held in_rdy", 96'(o_rdy[0]), 96'd0);
    chk("t1 u0 held head", 96'(o_seq[0]), 96'd1);
    out_rdy = 1; step();
    chk("t1 u0 in_rdy back", 96'(o_rdy[0]), 96'd1);
    chk("t1 u0 2nd seq", 96'(o_seq[0]), 96'd2);
    chk("t1 u0 2nd wdata", 96'(o_wdata[0]), 96'hA500_0002);
    step();
    drive(0, 0);
    chk("t1 u0 3rd seq", 96'(o_seq[0]), 96'd3);
    step(7);

    // 2. squash tail
    do_reset();
    commit_val = 1; commit_seq = 2; step(); commit_val = 0;
    for (int s = 3; s <= 6; s++) begin drive(1, 5'(s)); step(); end
    drive(0, 0);
    chk("t2 u1 full", 96'(o_rdy[1]), 96'd0);
    squash_val = 1; squash_seq = 4; #1;
    chk("t2 u1 head survives", 96'(o_val[1]), 96'd1);
    step(); squash_val = 0; #1;
    chk("t2 u1 rdy after squash", 96'(o_rdy[1]), 96'd1);
    chk("t2 u1 head seq", 96'(o_seq[1]), 96'd3);
    out_rdy = 1; step();
    chk("t2 u1 second seq", 96'(o_seq[1]), 96'd4);
    step();
    chk("t2 u1 empty", 96'(o_val[1]), 96'd0);
    step(2);

    // 3. squash head
    do_reset();
    commit_val = 1; commit_seq = 5; step(); commit_val = 0;
    drive(1, 7); step(); drive(0, 0);
    squash_val = 1; squash_seq = 6; out_rdy = 1; #1;
    chk("t3 u0 masked head", 96'(o_val[0]), 96'd0);
    step(); squash_val = 0; #1;
    chk("t3 u0 empty", 96'(o_val[0]), 96'd0);
    chk("t3 u1 empty", 96'(o_val[1]), 96'd0);
    step(2);

    // 4. wrap-around age
    do_reset();
    commit_val = 1; commit_seq = 29; step(); commit_val = 0;
    drive(1, 30); step(); drive(1, 31); step(); drive(1, 0); step(); drive(1, 1); step();
    drive(0, 0);
    squash_val = 1; squash_seq = 31; step(); squash_val = 0; #1;
    chk("t4 u1 head 30", 96'(o_seq[1]), 96'd30);
    chk("t4 u1 rdy", 96'(o_rdy[1]), 96'd1);
    out_rdy = 1; step();
    chk("t4 u1 next 31", 96'(o_seq[1]), 96'd31);
    chk("t4 u1 val 31", 96'(o_val[1]), 96'd1);
    step();
    chk("t4 u1 drained", 96'(o_val[1]), 96'd0);
    step(2);

    // 5. bypass
    do_reset();
    drive(1, 2); out_rdy = 1; #1;
    chk("t5 u2 bypass val", 96'(o_val[2]), 96'd1);
    chk("t5 u2 bypass seq", 96'(o_seq[2]), 96'd2);
    chk("t5 u0 no bypass", 96'(o_val[0]), 96'd0);
    step(); drive(0, 0); #1;
    chk("t5 u2 not enqueued", 96'(o_val[2]), 96'd0);
    drive(1, 2); squash_val = 1; squash_seq = 1; #1;
    chk("t5 u2 bypass squashed", 96'(o_val[2]), 96'd0);
    step(); drive(0, 0); squash_val = 0; #1;
    chk("t5 u2 still empty", 96'(o_val[2]), 96'd0);
    drive(1, 4); out_rdy = 0; step(); drive(0, 0); #1;
    chk("t5 u2 stalled bypass queued", 96'(o_val[2]), 96'd1);
    chk("t5 u2 queued seq", 96'(o_seq[2]), 96'd4);
    out_rdy = 1; step(2);

    // 6. async reset mid-operation
    do_reset();
    drive(1, 1); step(); drive(1, 2); step(); drive(0, 0);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("t6 u%0d async out_val", k), 96'(o_val[k]), 96'd0);
      chk($sformatf("t6 u%0d async in_rdy", k), 96'(o_rdy[k]), 96'd1);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    drive(1, 0); step(); drive(0, 0); out_rdy = 1; #1;
    chk("t6 u0 first after reset", 96'(o_seq[0]), 96'd0);
    chk("t6 u0 val after reset", 96'(o_val[0]), 96'd1);
    step();
    chk("t6 u0 no stale", 96'(o_val[0]), 96'd0);
    chk("t6 u1 no stale", 96'(o_val[1]), 96'd0);
    step(2);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
